// File: rtl/cpu_debug_arbiter.sv
// cpu_debug_arbiter: debug sequencer beside cpu_controller. Halts, resumes and single-steps
//   the core at instruction boundaries by gating its clock enable, and hands the data-RAM
//   port to an external debug requester while the core is halted.
// Optional feature macro: DBG_BREAKPOINT_EN (one PC breakpoint; SET_BP/CLR_BP rejected without it).
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_dbg_req/cmd/addr/wdata        debug command (req held until o_dbg_ack)
//   o_dbg_ack/err/rdata/halted      one-cycle completion, reject flag, read data, core-stopped
//   i_cpu_ifetch/pc/load_ram/ram_*  core-side boundary strobe, PC and RAM request
//   o_cpu_clk_en                    core clock enable (0 freezes every core register)
//   o_ram_addr/wdata/we, i_ram_rdata muxed RAM port (1-cycle synchronous read)
module cpu_debug_arbiter #(
  parameter int PC_WIDTH      = 9,
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 8,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_dbg_req,
  input  logic [2:0]            i_dbg_cmd,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  output logic                  o_dbg_ack,
  output logic                  o_dbg_err,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_dbg_halted,
  input  logic                  i_cpu_ifetch,
  input  logic [PC_WIDTH-1:0]   i_cpu_pc,
  input  logic                  i_cpu_load_ram,
  input  logic [ADDR_WIDTH-1:0] i_cpu_ram_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_ram_wdata,
  output logic                  o_cpu_clk_en,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_HALT   = 3'd1;
  localparam logic [2:0] CMD_RUN    = 3'd2;
  localparam logic [2:0] CMD_STEP   = 3'd3;
  localparam logic [2:0] CMD_RD_RAM = 3'd4;
  localparam logic [2:0] CMD_WR_RAM = 3'd5;
  localparam logic [2:0] CMD_SET_BP = 3'd6;
  localparam logic [2:0] CMD_CLR_BP = 3'd7;

`ifdef DBG_BREAKPOINT_EN
  localparam logic BP_CMD_ERR = 1'b0;
`else
  localparam logic BP_CMD_ERR = 1'b1;
`endif

  typedef enum logic [2:0] {
    S_RUN, S_HALT_PEND, S_HALTED, S_STEP, S_RD_ADDR, S_RD_DATA, S_WR, S_ACK
  } state_t;

  localparam state_t RESET_STATE = HALT_ON_RESET ? S_HALTED : S_RUN;

  state_t                r_state;
  state_t                w_nxt_state;
  logic                  r_ret_halted;    // where S_ACK returns to: 1 HALTED, 0 RUN
  logic                  w_nxt_ret_halted;
  logic                  r_err;           // only meaningful while in S_ACK
  logic                  w_nxt_err;
  logic                  r_ack_prev;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_accept;
  logic                  w_sfr;
  logic                  w_bp_hit;
  logic                  w_clk_en;
  logic                  w_dbg_own;
  logic                  w_dbg_we;

  // A command is only taken in a resting state; the cycle right after an ack is
  // skipped so a requester dropping dbg_req late is not seen as a new command.
  assign w_accept = i_dbg_req && !r_ack_prev && (r_state == S_RUN || r_state == S_HALTED);
  assign w_sfr    = (i_dbg_addr < ADDR_WIDTH'(8));

`ifdef DBG_BREAKPOINT_EN
  logic                r_bp_valid;
  logic [PC_WIDTH-1:0] r_bp_pc;
  logic [PC_WIDTH-1:0] w_bp_word;

  assign w_bp_word = PC_WIDTH'({i_dbg_addr, i_dbg_wdata});
  assign w_bp_hit  = r_bp_valid && i_cpu_ifetch && (i_cpu_pc == r_bp_pc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bp_valid <= 1'b0;
      r_bp_pc    <= '0;
    end else if (w_accept && i_dbg_cmd == CMD_SET_BP) begin
      r_bp_valid <= 1'b1;
      r_bp_pc    <= w_bp_word;
    end else if (w_accept && i_dbg_cmd == CMD_CLR_BP) begin
      r_bp_valid <= 1'b0;
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^i_cpu_pc;
  assign w_bp_hit    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= RESET_STATE;
      r_ret_halted <= HALT_ON_RESET;
      r_err        <= 1'b0;
      r_ack_prev   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_ret_halted <= w_nxt_ret_halted;
      r_err        <= w_nxt_err;
      r_ack_prev   <= o_dbg_ack;
      if (w_accept) begin
        r_addr  <= i_dbg_addr;
        r_wdata <= i_dbg_wdata;
      end
      if (r_state == S_RD_DATA) begin
        r_rdata <= i_ram_rdata;
      end
    end
  end

  // A breakpoint hit drops the clock enable in the hit cycle itself, so the core
  // stops before fetching the instruction at bp_pc (PC reads back as bp_pc).
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_ret_halted = r_ret_halted;
    w_nxt_err        = 1'b0;
    w_clk_en         = 1'b0;
    w_dbg_own        = 1'b0;
    w_dbg_we         = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_clk_en = !w_bp_hit;
        if (w_accept) begin
          w_nxt_state      = S_ACK;
          w_nxt_ret_halted = w_bp_hit;
          unique case (i_dbg_cmd)
            CMD_HALT:   if (!w_bp_hit) w_nxt_state = S_HALT_PEND;
            CMD_STEP,
            CMD_RD_RAM,
            CMD_WR_RAM: w_nxt_err = 1'b1;
            CMD_SET_BP,
            CMD_CLR_BP: w_nxt_err = BP_CMD_ERR;
            default:    w_nxt_err = 1'b0;
          endcase
        end else if (w_bp_hit) begin
          w_nxt_state = S_HALTED;
        end
      end
      S_HALT_PEND: begin
        w_clk_en = !w_bp_hit;
        if (i_cpu_ifetch || w_bp_hit) begin
          w_nxt_state      = S_ACK;
          w_nxt_ret_halted = 1'b1;
        end
      end
      S_HALTED: begin
        if (w_accept) begin
          w_nxt_state      = S_ACK;
          w_nxt_ret_halted = 1'b1;
          unique case (i_dbg_cmd)
            CMD_RUN:    w_nxt_ret_halted = 1'b0;
            CMD_STEP:   w_nxt_state = S_STEP;
            CMD_RD_RAM: if (w_sfr) w_nxt_err = 1'b1; else w_nxt_state = S_RD_ADDR;
            CMD_WR_RAM: if (w_sfr) w_nxt_err = 1'b1; else w_nxt_state = S_WR;
            CMD_SET_BP,
            CMD_CLR_BP: w_nxt_err = BP_CMD_ERR;
            default:    w_nxt_err = 1'b0;
          endcase
        end
      end
      // Enabled through the ifetch cycle so a multi-cycle instruction completes.
      S_STEP: begin
        w_clk_en = 1'b1;
        if (i_cpu_ifetch) begin
          w_nxt_state      = S_ACK;
          w_nxt_ret_halted = 1'b1;
        end
      end
      S_RD_ADDR: begin
        w_dbg_own   = 1'b1;
        w_nxt_state = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_dbg_own        = 1'b1;
        w_nxt_state      = S_ACK;
        w_nxt_ret_halted = 1'b1;
      end
      S_WR: begin
        w_dbg_own        = 1'b1;
        w_dbg_we         = 1'b1;
        w_nxt_state      = S_ACK;
        w_nxt_ret_halted = 1'b1;
      end
      S_ACK: begin
        w_clk_en    = !r_ret_halted && !w_bp_hit;
        w_nxt_state = (r_ret_halted || w_bp_hit) ? S_HALTED : S_RUN;
      end
      default: w_nxt_state = RESET_STATE;
    endcase
  end

  assign o_cpu_clk_en = w_clk_en;
  assign o_ram_addr   = w_dbg_own ? r_addr  : i_cpu_ram_addr;
  assign o_ram_wdata  = w_dbg_own ? r_wdata : i_cpu_ram_wdata;
  assign o_ram_we     = w_dbg_own ? w_dbg_we : (i_cpu_load_ram && w_clk_en);
  assign o_dbg_ack    = (r_state == S_ACK);
  assign o_dbg_err    = o_dbg_ack && r_err;
  assign o_dbg_rdata  = r_rdata;
  assign o_dbg_halted = (r_state == S_HALTED) || (r_state == S_RD_ADDR) ||
                        (r_state == S_RD_DATA) || (r_state == S_WR) ||
                        (r_state == S_ACK && r_ret_halted);

endmodule

// File: tb/tb_cpu_debug_arbiter.sv
module tb_cpu_debug_arbiter;

  localparam logic [2:0] NOP = 3'd0, HALT = 3'd1, RUN = 3'd2, STEP = 3'd3;
  localparam logic [2:0] RD = 3'd4, WR = 3'd5, SETBP = 3'd6, CLRBP = 3'd7;
  localparam logic [8:0] GOTO_PC = 9'h020, GOTO_TGT = 9'h030;
`ifdef DBG_BREAKPOINT_EN
  localparam logic BP_ERR = 1'b0;
`else
  localparam logic BP_ERR = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dbg_req = 1'b0;
  logic [2:0] dbg_cmd = 3'd0;
  logic [4:0] dbg_addr = 5'd0;
  logic [7:0] dbg_wdata = 8'd0;
  logic       dbg_ack, dbg_err, dbg_halted;
  logic [7:0] dbg_rdata;
  logic       cpu_ifetch, cpu_load_ram;
  logic [8:0] cpu_pc;
  logic [4:0] cpu_ram_addr;
  logic [7:0] cpu_ram_wdata;
  logic       cpu_clk_en;
  logic [4:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;

  cpu_debug_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_dbg_req(dbg_req), .i_dbg_cmd(dbg_cmd), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(dbg_ack), .o_dbg_err(dbg_err), .o_dbg_rdata(dbg_rdata), .o_dbg_halted(dbg_halted),
    .i_cpu_ifetch(cpu_ifetch), .i_cpu_pc(cpu_pc), .i_cpu_load_ram(cpu_load_ram),
    .i_cpu_ram_addr(cpu_ram_addr), .i_cpu_ram_wdata(cpu_ram_wdata),
    .o_cpu_clk_en(cpu_clk_en), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .o_ram_we(ram_we), .i_ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Core model: every instruction takes one cycle except the GOTO at GOTO_PC (two
  // cycles); cpu_ifetch is high on the last cycle of each instruction.
  logic [8:0] pc;
  logic       phase;
  int         retired;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= 9'd0; phase <= 1'b0; retired <= 0;
    end else if (cpu_clk_en) begin
      if (pc == GOTO_PC && !phase) phase <= 1'b1;
      else begin
        pc      <= (pc == GOTO_PC) ? GOTO_TGT : pc + 9'd1;
        phase   <= 1'b0;
        retired <= retired + 1;
      end
    end
  end
  assign cpu_pc        = pc;
  assign cpu_ifetch    = !(pc == GOTO_PC && !phase);
  assign cpu_load_ram  = pc[0];
  assign cpu_ram_addr  = {2'b00, pc[2:0]};
  assign cpu_ram_wdata = pc[7:0];

  // Data RAM with one-cycle synchronous read.
  logic [7:0] mem [0:31];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic prev_ack = 1'b0;
  string tag = "";

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    errors++;
    $display("FAIL %s %s: got %0h, want %0h", tag, name, act, exp);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) fail(name, act, exp);
  endtask

  always @(negedge clk) begin
    if (dbg_ack) ack_cnt++;
    if (rst_n) begin
      checks++;
      if (dbg_err && !dbg_ack) fail("err_without_ack", 1, 0);
      if (dbg_ack && prev_ack) fail("ack_width", 2, 1);
      if (!dbg_halted && ram_we !== (cpu_load_ram & cpu_clk_en))
        fail("ram_we_core_side", ram_we, cpu_load_ram & cpu_clk_en);
    end
    prev_ack = dbg_ack;
  end

  typedef struct {
    logic [2:0] cmd;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       exp_err;
    logic       chk_rd;
    logic [7:0] exp_rdata;
    logic       exp_halted;
    int         exp_lat;   // negedges from drive to ack; 0 = not checked
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] c, input logic [4:0] a, input logic [7:0] w,
                              input logic e, input logic cr, input logic [7:0] r,
                              input logic h, input int l);
    vec_t v;
    v.cmd = c; v.addr = a; v.wdata = w; v.exp_err = e; v.chk_rd = cr;
    v.exp_rdata = r; v.exp_halted = h; v.exp_lat = l;
    return v;
  endfunction

  task automatic do_cmd(input vec_t v);
    vec_t e;
    int   n;
    bit   got;
    sb_q.push_back(v);
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_cmd = v.cmd; dbg_addr = v.addr; dbg_wdata = v.wdata;
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(negedge clk); n++;
      if (dbg_ack) got = 1;
    end
    e = sb_q.pop_front();
    if (!got) begin
      checks++;
      fail("ack_timeout", n, e.exp_lat);
    end else begin
      chk("err", dbg_err, e.exp_err);
      chk("halted", dbg_halted, e.exp_halted);
      chk("clk_en_at_ack", cpu_clk_en, !e.exp_halted);
      if (e.exp_lat != 0) chk("latency", n, e.exp_lat);
      if (e.chk_rd) chk("rdata", dbg_rdata, e.exp_rdata);
    end
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] p0;
    int         r0, a0, a1, n;
    bit         seen;

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    // Reset values.
    tag = "reset";
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ack", dbg_ack, 0);
    chk("err", dbg_err, 0);
    chk("rdata", dbg_rdata, 0);
    chk("halted", dbg_halted, 0);
    chk("clk_en", cpu_clk_en, 1);

    // HALT mid-program: one ack, core frozen afterwards.
    repeat (8) @(posedge clk);
    tag = "halt_mid";
    a0 = ack_cnt;
    do_cmd(mk(HALT, 0, 0, 0, 0, 0, 1, 0));
    chk("one_ack", ack_cnt, a0 + 1);
    chk("clk_en_off", cpu_clk_en, 0);
    p0 = pc;
    repeat (5) @(posedge clk);
    #1;
    chk("pc_frozen", pc, p0);
    chk("no_extra_ack", ack_cnt, a0 + 1);

    // Single steps up to the GOTO, then across it.
    tag = "step";
    for (int k = 0; k < 64 && pc != GOTO_PC; k++) begin
      p0 = pc; r0 = retired;
      do_cmd(mk(STEP, 0, 0, 0, 0, 0, 1, 3));
      chk("retire", retired, r0 + 1);
      chk("pc", pc, 9'(p0 + 9'd1));
    end
    tag = "step_goto";
    chk("at_goto", pc, GOTO_PC);
    r0 = retired;
    do_cmd(mk(STEP, 0, 0, 0, 0, 0, 1, 4));
    chk("retire", retired, r0 + 1);
    chk("pc", pc, GOTO_TGT);
    chk("halted", dbg_halted, 1);

    // Command table, starting halted.
    vecs.push_back(mk(WR,   5'h0A, 8'h5C, 0, 0, 0,     1, 3));
    vecs.push_back(mk(RD,   5'h0A, 8'h00, 0, 1, 8'h5C, 1, 4));
    vecs.push_back(mk(WR,   5'h1F, 8'hA3, 0, 0, 0,     1, 3));
    vecs.push_back(mk(RD,   5'h1F, 8'h00, 0, 1, 8'hA3, 1, 4));
    vecs.push_back(mk(WR,   5'h08, 8'h11, 0, 0, 0,     1, 3));
    vecs.push_back(mk(RD,   5'h08, 8'h00, 0, 1, 8'h11, 1, 4));
    vecs.push_back(mk(WR,   5'h07, 8'hEE, 1, 0, 0,     1, 2));
    vecs.push_back(mk(RD,   5'h03, 8'h00, 1, 1, 8'h11, 1, 2));
    vecs.push_back(mk(NOP,  5'h00, 8'h00, 0, 0, 0,     1, 2));
    vecs.push_back(mk(HALT, 5'h00, 8'h00, 0, 0, 0,     1, 2));
    vecs.push_back(mk(SETBP,5'h00, 8'hFF, BP_ERR, 0, 0, 1, 2));
    vecs.push_back(mk(CLRBP,5'h00, 8'h00, BP_ERR, 0, 0, 1, 2));
    vecs.push_back(mk(RUN,  5'h00, 8'h00, 0, 0, 0,     0, 2));
    vecs.push_back(mk(STEP, 5'h00, 8'h00, 1, 0, 0,     0, 2));
    vecs.push_back(mk(RD,   5'h0A, 8'h00, 1, 0, 0,     0, 2));
    vecs.push_back(mk(WR,   5'h0A, 8'h77, 1, 0, 0,     0, 2));
    vecs.push_back(mk(RUN,  5'h00, 8'h00, 0, 0, 0,     0, 2));
    vecs.push_back(mk(NOP,  5'h00, 8'h00, 0, 0, 0,     0, 2));
    vecs.push_back(mk(HALT, 5'h00, 8'h00, 0, 0, 0,     1, 0));
    vecs.push_back(mk(RD,   5'h0A, 8'h00, 0, 1, 8'h5C, 1, 4));
    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      do_cmd(vecs[i]);
    end

`ifdef DBG_BREAKPOINT_EN
    // Breakpoint at 0x012 halts without an ack; after clearing it the core runs past.
    tag = "bp";
    do_cmd(mk(SETBP, 5'h00, 8'h12, 0, 0, 0, 1, 2));
    do_cmd(mk(RUN, 0, 0, 0, 0, 0, 0, 2));
    a1 = ack_cnt;
    seen = 0; n = 0;
    while (!seen && n < 2000) begin
      @(negedge clk); n++;
      if (dbg_halted) seen = 1;
    end
    chk("bp_halt_seen", seen, 1);
    chk("bp_pc", pc, 9'h012);
    chk("bp_no_ack", ack_cnt, a1);
    chk("bp_clk_en", cpu_clk_en, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_pc_frozen", pc, 9'h012);
    do_cmd(mk(CLRBP, 0, 0, 0, 0, 0, 1, 2));
    do_cmd(mk(RUN, 0, 0, 0, 0, 0, 0, 2));
    repeat (20) @(posedge clk);
    #1;
    chk("bp_cleared_running", dbg_halted, 0);
    chk("bp_passed", (pc > 9'h012 && pc < 9'h040), 1);
    do_cmd(mk(HALT, 0, 0, 0, 0, 0, 1, 0));
`endif

    // Reset during RD_ADDR aborts the read with no ack.
    tag = "rst_mid_rd";
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_cmd = RD; dbg_addr = 5'h0A;
    @(posedge clk); #1;
    rst_n = 1'b0;
    a0 = ack_cnt;
    @(negedge clk);
    chk("ack", dbg_ack, 0);
    chk("err", dbg_err, 0);
    chk("rdata", dbg_rdata, 0);
    chk("halted", dbg_halted, 0);
    chk("clk_en", cpu_clk_en, 1);
    dbg_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_ack", ack_cnt, a0);
    chk("running", dbg_halted, 0);
    chk("pc_advances", (pc != 9'd0), 1);

    tag = "end";
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
